io_uart_responder: RTL
======================

Name: io_uart_responder

Overview:
- Responder on the CPU IO bus (io_rd/io_wr/io_addr/io_dout/io_din plus interrupt_request): the peripheral end the processor talks to.
- Provides an 8N1 UART with a TX holding register, a TX shifter, an RX deserialiser, an RX FIFO, sticky error flags and a level interrupt request back to the CPU.
- Instantiated beside the core in the top level.

Parameters:
- CLKS_PER_BIT, 104, clocks per UART bit (>=4); 104 = 115200 baud at 12 MHz.
- RX_DEPTH, 8, RX FIFO entries; power of two, 2..64.
- DATA_ADDR, 16'h1000, one-hot address bit selecting the data register.
- FLAGS_ADDR, 16'h2000, one-hot address bit selecting the flags register.
- IRQ_ADDR, 16'h4000, one-hot address bit selecting the interrupt mask register.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- io_rd  in  1  read strobe, one cycle.
- io_wr  in  1  write strobe, one cycle.
- io_addr  in  16  IO address.
- io_dout  in  16  write data from CPU.
- io_din  out  16  read data to CPU, combinational.
- interrupt_request  out  1  level IRQ to CPU, registered.
- uart_rx  in  1  asynchronous serial input.
- uart_tx  out  1  serial output, idle high.

Behaviour:
- Decode: a register is selected when (io_addr & X_ADDR) != 0. When several registers are selected, io_din is the OR of their read values; writes go to every selected register.
- io_din is purely combinational from io_addr and state, so the CPU captures it in the same cycle as io_rd. Read side effects happen on the clk edge where io_rd=1.
- Data read: {8'h00, RX head}, or 16'h0000 if the FIFO is empty. Pops one entry if non-empty; no effect if empty.
- Data write: if the holding register is empty, load io_dout[7:0] and mark it full. If full, the write is silently dropped; there is no stall path.
- Flags read: bit0 tx_full (holding occupied), bit1 rx_valid, bit2 rx_overrun (sticky), bit3 frame_err (sticky), bit4 tx_active (shifter busy). Bits 15:5 read 0.
- Flags write: write-1-to-clear on bits 2 and 3. A set event in the same cycle wins over the clear.
- IRQ register: bit0 enables rx_valid, bit1 enables tx holding empty. Read returns {14'b0, mask}. Reset value 0.
- TX FSM, states IDLE/START/DATA/STOP:
  - IDLE: when holding is full, move the byte to the shifter, clear holding and go to START in the same edge.
  - Each state lasts CLKS_PER_BIT cycles. DATA sends 8 bits, LSB first. STOP drives 1.
  - If holding is full at the end of STOP, go directly to START (back-to-back, no idle gap).
- RX path:
  - 2-flop synchroniser on uart_rx, both flops reset to 1.
  - IDLE: on a synchronised falling edge, wait CLKS_PER_BIT/2 cycles, then resample. If high, treat as a false start and return to IDLE.
  - Sample the 8 data bits at mid-bit, then the stop bit.
  - Stop=1: push the byte. If the FIFO is full and no pop occurs in the same cycle, drop the byte and set rx_overrun. A simultaneous push and pop on a full FIFO succeeds with no overrun.
  - Stop=0: set frame_err, discard the byte, and wait for the line to return high before IDLE.
- interrupt_request <= |(mask & {~tx_full, rx_valid}), registered one cycle after the condition.
- Reset: uart_tx=1, interrupt_request=0, FIFO empty, holding empty, flags 0, mask 0, both FSMs IDLE. Reset mid-frame aborts immediately; uart_tx returns high on the next edge.

Optional Feature:
- IO_UART_IRQ_EN defined: the IRQ register and interrupt_request logic are present as described.
- IO_UART_IRQ_EN undefined: interrupt_request is constant 0, IRQ register reads 0, and writes to it are ignored.

Test Plan:
- CLKS_PER_BIT=4. Write 16'h0041 to 16'h1000 -> uart_tx low 4 clk (start), then 1,0,0,0,0,0,1,0 at 4 clk each, then high 4 clk. Flags bit4=1 during the frame.
- Two back-to-back writes 16'h0055 then 16'h00AA, then a third while both are occupied -> two contiguous frames, third byte dropped, flags bit0=1 after the second write.
- Drive RX frame 8'h3C -> flags read 16'h0002. Data read returns 16'h003C, then flags 16'h0000; a further data read returns 16'h0000.
- Send RX_DEPTH+1 bytes with no reads -> flags bit2=1 and FIFO holds the first RX_DEPTH bytes in order. Write 16'h0004 to flags -> bit2 clears.
- RX frame with stop bit 0 -> frame_err=1, FIFO unchanged. A 1-clk low glitch on uart_rx -> nothing received.
- IRQ_EN build: write 16'h0001 to 16'h4000, then receive a byte -> interrupt_request=1. Read data -> interrupt_request=0 one cycle later. Write mask 16'h0002 while idle -> interrupt_request=1.

Source files
------------

// File: rtl/io_uart_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : io_uart_responder
//  Purpose  : 8N1 UART peripheral on the CPU IO bus. Provides a TX holding
//             register feeding a TX shifter, an RX deserialiser feeding an RX
//             FIFO, sticky overrun/framing flags and a level interrupt request.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk               system clock, rising edge
//    reset             synchronous active-high reset
//    io_rd / io_wr     one-cycle read / write strobes
//    io_addr           IO address, registers selected by one-hot address bits
//    io_dout           write data from CPU
//    io_din            read data to CPU (combinational)
//    interrupt_request level interrupt to CPU (registered)
//    uart_rx           asynchronous serial input
//    uart_tx           serial output, idle high
//  Build option
//    IO_UART_IRQ_EN    when defined, the interrupt mask register and the
//                      interrupt_request logic are present; otherwise the
//                      mask reads 0, ignores writes and the IRQ is tied low.
// ============================================================================
module io_uart_responder #(
    parameter int          CLKS_PER_BIT = 104,
    parameter int          RX_DEPTH     = 8,
    parameter logic [15:0] DATA_ADDR    = 16'h1000,
    parameter logic [15:0] FLAGS_ADDR   = 16'h2000,
    parameter logic [15:0] IRQ_ADDR     = 16'h4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_dout,
    output logic [15:0] io_din,
    output logic        interrupt_request,
    input  logic        uart_rx,
    output logic        uart_tx
);

    localparam int            CW          = $clog2(CLKS_PER_BIT);
    localparam int            AW          = $clog2(RX_DEPTH);
    localparam logic [CW-1:0] c_bit_last  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_half_last = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]   c_depth     = (AW+1)'(RX_DEPTH);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic w_sel_data, w_sel_flags, w_sel_irq;
    logic w_rd_data, w_wr_data, w_wr_flags;

    assign w_sel_data  = |(io_addr & DATA_ADDR);
    assign w_sel_flags = |(io_addr & FLAGS_ADDR);
    assign w_sel_irq   = |(io_addr & IRQ_ADDR);
    assign w_rd_data   = io_rd & w_sel_data;
    assign w_wr_data   = io_wr & w_sel_data;
    assign w_wr_flags  = io_wr & w_sel_flags;

    // Only the low byte and two flag bits of io_dout are meaningful.
    logic w_unused_bits;
    assign w_unused_bits = ^{io_dout, w_sel_irq};

    // ------------------------------------------------------------------
    // TX holding register
    // ------------------------------------------------------------------
    logic       r_hold_full;
    logic [7:0] r_hold_data;
    logic       w_tx_take;

    // The shifter only takes the byte while full and the CPU only loads it
    // while empty, so the two branches never compete.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_full <= 1'b0;
            r_hold_data <= 8'h00;
        end else if (w_tx_take) begin
            r_hold_full <= 1'b0;
        end else if (w_wr_data && !r_hold_full) begin
            r_hold_full <= 1'b1;
            r_hold_data <= io_dout[7:0];
        end
    end

    // ------------------------------------------------------------------
    // TX shifter FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    tx_state_t     r_tx_state, w_tx_state_nxt;
    logic [CW-1:0] r_tx_cnt, w_tx_cnt_nxt;
    logic [2:0]    r_tx_bit, w_tx_bit_nxt;
    logic [7:0]    r_tx_shift, w_tx_shift_nxt;
    logic          r_tx_out, w_tx_out_nxt;
    logic          w_tx_cnt_last;

    assign w_tx_cnt_last = (r_tx_cnt == c_bit_last);

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_take      = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (r_hold_full) begin
                    w_tx_take      = 1'b1;
                    w_tx_shift_nxt = r_hold_data;
                    w_tx_cnt_nxt   = '0;
                    w_tx_state_nxt = TX_START;
                end
            end
            TX_START: begin
                if (w_tx_cnt_last) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_bit_nxt   = 3'd0;
                    w_tx_state_nxt = TX_DATA;
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt + 1'b1;
                end
            end
            TX_DATA: begin
                if (w_tx_cnt_last) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_shift_nxt = {1'b1, r_tx_shift[7:1]};
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_nxt = TX_STOP;
                    end else begin
                        w_tx_bit_nxt = r_tx_bit + 1'b1;
                    end
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt + 1'b1;
                end
            end
            TX_STOP: begin
                if (w_tx_cnt_last) begin
                    w_tx_cnt_nxt = '0;
                    // A waiting byte starts immediately: no idle gap.
                    if (r_hold_full) begin
                        w_tx_take      = 1'b1;
                        w_tx_shift_nxt = r_hold_data;
                        w_tx_state_nxt = TX_START;
                    end else begin
                        w_tx_state_nxt = TX_IDLE;
                    end
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt + 1'b1;
                end
            end
            default: begin
                w_tx_state_nxt = TX_IDLE;
            end
        endcase
    end

    // Line level follows the next state so uart_tx is a plain flop output.
    always_comb begin
        w_tx_out_nxt = 1'b1;
        if (w_tx_state_nxt == TX_START) begin
            w_tx_out_nxt = 1'b0;
        end else if (w_tx_state_nxt == TX_DATA) begin
            w_tx_out_nxt = w_tx_shift_nxt[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'h00;
            r_tx_out   <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_out   <= w_tx_out_nxt;
        end
    end

    assign uart_tx = r_tx_out;

    // ------------------------------------------------------------------
    // RX synchroniser and edge detect
    // ------------------------------------------------------------------
    logic r_rx_s1, r_rx_s2, r_rx_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= uart_rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    // ------------------------------------------------------------------
    // RX deserialiser FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_WAIT  = 3'd4
    } rx_state_t;

    rx_state_t     r_rx_state, w_rx_state_nxt;
    logic [CW-1:0] r_rx_cnt, w_rx_cnt_nxt;
    logic [2:0]    r_rx_bit, w_rx_bit_nxt;
    logic [7:0]    r_rx_shift, w_rx_shift_nxt;
    logic          w_rx_push_req;
    logic          w_frame_set;
    logic          w_rx_cnt_last;

    assign w_rx_cnt_last = (r_rx_cnt == c_bit_last);

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_push_req  = 1'b0;
        w_frame_set    = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (r_rx_prev && !r_rx_s2) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                // Half a bit in: recheck the start bit to reject glitches.
                if (r_rx_cnt == c_half_last) begin
                    w_rx_cnt_nxt = '0;
                    if (r_rx_s2) begin
                        w_rx_state_nxt = RX_IDLE;
                    end else begin
                        w_rx_bit_nxt   = 3'd0;
                        w_rx_state_nxt = RX_DATA;
                    end
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (w_rx_cnt_last) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_shift_nxt = {r_rx_s2, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) begin
                        w_rx_state_nxt = RX_STOP;
                    end else begin
                        w_rx_bit_nxt = r_rx_bit + 1'b1;
                    end
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (w_rx_cnt_last) begin
                    w_rx_cnt_nxt = '0;
                    if (r_rx_s2) begin
                        w_rx_push_req  = 1'b1;
                        w_rx_state_nxt = RX_IDLE;
                    end else begin
                        w_frame_set    = 1'b1;
                        w_rx_state_nxt = RX_WAIT;
                    end
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + 1'b1;
                end
            end
            RX_WAIT: begin
                if (r_rx_s2) begin
                    w_rx_state_nxt = RX_IDLE;
                end
            end
            default: begin
                w_rx_state_nxt = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'h00;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO (pointers carry one extra wrap bit)
    // ------------------------------------------------------------------
    logic [7:0]  r_fifo [RX_DEPTH];
    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0] w_count;
    logic        w_empty, w_full, w_pop, w_push, w_ovr_set;
    logic [7:0]  w_head;

    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign w_empty   = (w_count == '0);
    assign w_full    = (w_count == c_depth);
    assign w_head    = r_fifo[r_rd_ptr[AW-1:0]];
    assign w_pop     = w_rd_data & ~w_empty;
    // A pop in the same cycle frees the slot the push needs.
    assign w_push    = w_rx_push_req & (~w_full | w_pop);
    assign w_ovr_set = w_rx_push_req & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[AW-1:0]] <= r_rx_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags: write-1-to-clear, a same-cycle set wins
    // ------------------------------------------------------------------
    logic r_overrun, r_frame_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overrun   <= w_ovr_set   | (r_overrun   & ~(w_wr_flags & io_dout[2]));
            r_frame_err <= w_frame_set | (r_frame_err & ~(w_wr_flags & io_dout[3]));
        end
    end

    // ------------------------------------------------------------------
    // Interrupt mask and request
    // ------------------------------------------------------------------
    logic [1:0] w_irq_mask;

`ifdef IO_UART_IRQ_EN
    logic [1:0] r_irq_mask;
    logic       r_irq;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_mask <= 2'b00;
            r_irq      <= 1'b0;
        end else begin
            if (io_wr && w_sel_irq) begin
                r_irq_mask <= io_dout[1:0];
            end
            r_irq <= |(r_irq_mask & {~r_hold_full, ~w_empty});
        end
    end

    assign w_irq_mask        = r_irq_mask;
    assign interrupt_request = r_irq;
`else
    assign w_irq_mask        = 2'b00;
    assign interrupt_request = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read data: OR of every selected register
    // ------------------------------------------------------------------
    logic [15:0] w_rd_val;

    always_comb begin
        w_rd_val = 16'h0000;
        if (w_sel_data && !w_empty) begin
            w_rd_val = w_rd_val | {8'h00, w_head};
        end
        if (w_sel_flags) begin
            w_rd_val = w_rd_val | {11'b0, (r_tx_state != TX_IDLE), r_frame_err,
                                   r_overrun, ~w_empty, r_hold_full};
        end
        if (w_sel_irq) begin
            w_rd_val = w_rd_val | {14'b0, w_irq_mask};
        end
    end

    assign io_din = w_rd_val;

endmodule
`default_nettype wire
